mv_median_filter: RTL

Parametrised successor of the motion-vector median filter stage. It raster-scans a motion-vector field of width x height blocks held in external memory and fetches each centre and its 3x3 neighbourhood through a request/acknowledge read port. It emits one filtered value per block on a ready/valid output stream. Each sample carries a NULL flag in its MSB; the block fills NULL vectors only (mode 0) or smooths every vector (mode 1). It sits between the motion-estimation result memory and the vector writer.

---
 rtl/mv_mf_pkg.sv | 41 ++++
 rtl/mv_median9.sv | 75 +++++++
 rtl/mv_median_filter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mv_mf_pkg.sv
// Shared state encoding, padding constants and neighbour visit table
// for the motion-vector median filter.
package mv_mf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CENTRE,
        ST_NEIGH,
        ST_SORT,
        ST_EMIT,
        ST_DONE
    } mf_state_t;

    localparam int NB_COUNT = 8;
    localparam int PAD_W    = 64;
    localparam logic [PAD_W-1:0] PAD_LO = '0;
    localparam logic [PAD_W-1:0] PAD_HI = '1;

    // The NULL flag occupies the bit just above the data field.
    function automatic int null_bit(input int dw);
        return dw;
    endfunction

    // Offsets are encoded as 0 = -1, 1 = 0, 2 = +1 so they stay unsigned.
    function automatic logic [1:0] nb_dx(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd3, 3'd5: nb_dx = 2'd0;
            3'd1, 3'd6:       nb_dx = 2'd1;
            default:          nb_dx = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] nb_dy(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: nb_dy = 2'd0;
            3'd3, 3'd4:       nb_dy = 2'd1;
            default:          nb_dy = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/mv_median9.sv
// Registered three-stage 9-input median network (row sort, column
// reduction, final median of three).
module mv_median9
    import mv_mf_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data [9],
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [DW-1:0] row_max [3];
    logic [DW-1:0] row_med [3];
    logic [DW-1:0] row_min [3];
    logic [DW-1:0] s2_lo, s2_md, s2_hi;
    logic          v1, v2;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++) begin
                row_max[r] <= '0;
                row_med[r] <= '0;
                row_min[r] <= '0;
            end
            s2_lo     <= '0;
            s2_md     <= '0;
            s2_hi     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                row_max[r] <= max3(in_data[3*r], in_data[3*r+1], in_data[3*r+2]);
                row_med[r] <= med3(in_data[3*r], in_data[3*r+1], in_data[3*r+2]);
                row_min[r] <= min3(in_data[3*r], in_data[3*r+1], in_data[3*r+2]);
            end
            v1        <= in_valid;
            s2_lo     <= min3(row_max[0], row_max[1], row_max[2]);
            s2_md     <= med3(row_med[0], row_med[1], row_med[2]);
            s2_hi     <= max3(row_min[0], row_min[1], row_min[2]);
            v2        <= v1;
            out_data  <= med3(s2_lo, s2_md, s2_hi);
            out_valid <= v2;
        end
    end

endmodule

// File: rtl/mv_median_filter.sv
// Raster-scans a motion-vector field, fetches each 3x3 neighbourhood over
// a req/ack read port and streams out NULL-filled or smoothed vectors.
module mv_median_filter
    import mv_mf_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int AW = 16
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] height,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ack,
    input  logic [DW:0]   rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic [DW:0]   out_data,
    output logic          out_filtered,
    output logic          busy,
    output logic          done
);

    localparam int NULL_BIT = null_bit(DW);

    mf_state_t     state, state_next;
    logic          mode_r;
    logic [CW-1:0] width_r, height_r, x, y;
    logic [2:0]    nidx;
    logic [3:0]    k;
    logic [DW-1:0] samples [9];
    logic [DW-1:0] window [9];
    logic          sort_started;
    logic [CW:0]   nx, ny, read_x, read_y;
    logic [AW-1:0] addr_calc;
    logic          nb_in_frame, nb_step, accept, last_block, sample_null;
    logic          med_in_valid, med_valid;
    logic [DW-1:0] med_out;

    always_comb begin
        nx          = (CW+1)'(x) + (CW+1)'(nb_dx(nidx)) - (CW+1)'(1);
        ny          = (CW+1)'(y) + (CW+1)'(nb_dy(nidx)) - (CW+1)'(1);
        nb_in_frame = (nx != '0) && (ny != '0) &&
                      (nx <= (CW+1)'(width_r)) && (ny <= (CW+1)'(height_r));
        read_x      = (state == ST_CENTRE) ? (CW+1)'(x) : nx;
        read_y      = (state == ST_CENTRE) ? (CW+1)'(y) : ny;
        addr_calc   = AW'(read_y - (CW+1)'(1)) * AW'(width_r) + AW'(read_x - (CW+1)'(1));
        sample_null = rd_data[NULL_BIT];
        nb_step     = !nb_in_frame || rd_ack;
        accept      = (state == ST_EMIT) && out_ready;
        last_block  = (x == width_r) && (y == height_r);
        med_in_valid = (state == ST_SORT) && !sort_started;
    end

    // Unfilled window slots alternate low/high so padding cancels out in the median.
    always_comb begin
        for (int p = 0; p < 9; p++) begin
            window[p] = samples[p];
            if (4'(p) >= k) begin
                window[p] = (p % 2 == 0) ? DW'(PAD_LO) : DW'(PAD_HI);
            end
        end
    end

    always_comb begin
        rd_req    = (state == ST_CENTRE) || ((state == ST_NEIGH) && nb_in_frame);
        rd_addr   = rd_req ? addr_calc : '0;
        out_valid = (state == ST_EMIT);
        busy      = (state == ST_CENTRE) || (state == ST_NEIGH) ||
                    (state == ST_SORT) || (state == ST_EMIT);
        done      = (state == ST_DONE);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (width == '0 || height == '0) ? ST_DONE : ST_CENTRE;
                end
            end
            ST_CENTRE: begin
                if (rd_ack) begin
                    state_next = (!mode_r && !sample_null) ? ST_EMIT : ST_NEIGH;
                end
            end
            ST_NEIGH: begin
                if (nb_step && nidx == 3'(NB_COUNT - 1)) state_next = ST_SORT;
            end
            ST_SORT: begin
                if (med_valid) state_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (accept) state_next = last_block ? ST_DONE : ST_CENTRE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            mode_r       <= 1'b0;
            width_r      <= '0;
            height_r     <= '0;
            x            <= '0;
            y            <= '0;
            nidx         <= '0;
            k            <= '0;
            sort_started <= 1'b0;
            out_x        <= '0;
            out_y        <= '0;
            out_data     <= '0;
            out_filtered <= 1'b0;
            for (int p = 0; p < 9; p++) samples[p] <= '0;
        end else begin
            sort_started <= (state == ST_SORT);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r   <= mode;
                        width_r  <= width;
                        height_r <= height;
                        x        <= CW'(1);
                        y        <= CW'(1);
                    end
                end
                ST_CENTRE: begin
                    if (rd_ack) begin
                        out_x <= x;
                        out_y <= y;
                        nidx  <= '0;
                        k     <= '0;
                        if (!mode_r && !sample_null) begin
                            out_data     <= rd_data;
                            out_filtered <= 1'b0;
                        end else if (mode_r && !sample_null) begin
                            samples[0] <= rd_data[DW-1:0];
                            k          <= 4'd1;
                        end
                    end
                end
                ST_NEIGH: begin
                    if (nb_step) begin
                        nidx <= nidx + 3'd1;
                        if (nb_in_frame && rd_ack && !sample_null) begin
                            samples[k] <= rd_data[DW-1:0];
                            k          <= k + 4'd1;
                        end
                    end
                end
                ST_SORT: begin
                    if (med_valid) begin
                        out_data     <= (k == '0) ? {1'b1, DW'(0)} : {1'b0, med_out};
                        out_filtered <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (x == width_r) begin
                            x <= CW'(1);
                            y <= y + CW'(1);
                        end else begin
                            x <= x + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    mv_median9 #(.DW(DW)) u_median (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .in_valid  (med_in_valid),
        .in_data   (window),
        .out_valid (med_valid),
        .out_data  (med_out)
    );

endmodule
